// File: rtl/btn_debounce_array.sv
// Multi-channel push-button debouncer: per channel a 2-flop synchroniser,
// a press/release FSM with hold-time counter, one-cycle press/release
// pulses and a debounced level. Optional auto-repeat of press while held
// is enabled by defining BTN_DEBOUNCE_REPEAT_EN.
// Ports: clk, rst_n (async, active low), btn[CH] raw inputs,
// press[CH] / released[CH] one-cycle pulses, level[CH] debounced state,
// any_press = registered OR of press.
module btn_debounce_array #(
  parameter int CH            = 4,
  parameter int DELAY_TIME    = 1000000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] press,
  output logic [CH-1:0] released,
  output logic [CH-1:0] level,
  output logic          any_press
);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  localparam longint CMAX = (64'd1 << CNT_W) - 64'd1;

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("btn_debounce_array: CH out of range");
  end
  if (DELAY_TIME < 1 || longint'(DELAY_TIME - 1) > CMAX) begin : g_bad_dly
    $error("btn_debounce_array: DELAY_TIME does not fit CNT_W");
  end
  if (REPEAT_DELAY < 1 || longint'(REPEAT_DELAY - 1) > CMAX
      || REPEAT_PERIOD < 1
      || longint'(REPEAT_PERIOD - 1) > CMAX) begin : g_bad_rpt
    $error("btn_debounce_array: REPEAT_* does not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(DELAY_TIME - 1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_M1  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_M1  = CNT_W'(REPEAT_PERIOD - 1);
`endif

  // Synchroniser idles at the released level so reset never looks like
  // a press.
  localparam logic [CH-1:0] INACT =
    (ACTIVE_LOW != 0) ? {CH{1'b1}} : {CH{1'b0}};

  logic [CH-1:0] sync1;
  logic [CH-1:0] btn_s;
  logic [CH-1:0] press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INACT;
      btn_s <= INACT;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pr_q, pr_d;
    logic             rl_q, rl_d;
    logic             lv_q, lv_d;
    logic             act;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    // Set while waiting for the first repeat, cleared afterwards.
    logic             first_q, first_d;
`endif

    assign act = (ACTIVE_LOW != 0) ? ~btn_s[i] : btn_s[i];

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      pr_d  = 1'b0;
      rl_d  = 1'b0;
      lv_d  = lv_q;
`ifdef BTN_DEBOUNCE_REPEAT_EN
      first_d = first_q;
`endif
      unique case (st_q)
        IDLE: begin
          cnt_d = '0;
          if (act) st_d = DB_PRESS;
        end
        DB_PRESS: begin
          if (!act) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_q == DLY_M1) begin
            st_d  = HELD;
            cnt_d = '0;
            pr_d  = 1'b1;
            lv_d  = 1'b1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            first_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!act) begin
            st_d  = DB_RELEASE;
            cnt_d = '0;
          end else begin
`ifdef BTN_DEBOUNCE_REPEAT_EN
            if (cnt_q == (first_q ? RD_M1 : RP_M1)) begin
              cnt_d   = '0;
              pr_d    = 1'b1;
              first_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`else
            cnt_d = '0;
`endif
          end
        end
        DB_RELEASE: begin
          if (act) begin
            // Bounce back to held: no new press, repeat timing restarts.
            st_d  = HELD;
            cnt_d = '0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            first_d = 1'b1;
`endif
          end else if (cnt_q == DLY_M1) begin
            st_d  = IDLE;
            cnt_d = '0;
            rl_d  = 1'b1;
            lv_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        pr_q  <= 1'b0;
        rl_q  <= 1'b0;
        lv_q  <= 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        first_q <= 1'b0;
`endif
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        pr_q  <= pr_d;
        rl_q  <= rl_d;
        lv_q  <= lv_d;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        first_q <= first_d;
`endif
      end
    end

    assign press[i]    = pr_q;
    assign released[i] = rl_q;
    assign level[i]    = lv_q;
    assign press_d[i]  = pr_d;
  end

  // Built from next-state pulses so it lines up with press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |press_d;
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Self-checking bench for btn_debounce_array: run-length reference model
// compared every cycle, plus directed scenarios with literal timings.
module tb_btn_debounce_array;

  localparam int CH = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] btn = '1;
  logic [CH-1:0] press;
  logic [CH-1:0] released;
  logic [CH-1:0] level;
  logic          any_press;

  int total = 0;
  int bad = 0;

  btn_debounce_array #(
    .CH(CH), .DELAY_TIME(D), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .press(press), .released(released),
    .level(level), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference: the debounced input is the pin as sampled two edges
  // earlier. An event fires on the edge where that input has shown the
  // same value for D+1 consecutive samples against the current level.
  logic [CH-1:0] m_p1, m_p2, m_prev, m_lvl, e_press, e_rel;
  logic          e_any;
  int            run [CH];
  int            base [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = '1; m_p2 = '1; m_prev = '1;
      m_lvl = '0; e_press = '0; e_rel = '0; e_any = 1'b0;
      for (int i = 0; i < CH; i++) begin
        run[i] = 0; base[i] = 0;
      end
    end else begin
      e_press = '0; e_rel = '0;
      for (int i = 0; i < CH; i++) begin
        logic s, act;
        int k;
        s = m_p2[i];
        act = ~s;
        if (s == m_prev[i]) begin
          if (run[i] < 1000000) run[i]++;
        end else begin
          run[i] = 1;
        end
        m_prev[i] = s;
        if (!m_lvl[i] && act && run[i] == D + 1) begin
          e_press[i] = 1'b1; m_lvl[i] = 1'b1; base[i] = run[i];
        end else if (m_lvl[i] && !act && run[i] == D + 1) begin
          e_rel[i] = 1'b1; m_lvl[i] = 1'b0;
        end else if (m_lvl[i] && act) begin
          if (run[i] == 1) base[i] = 1;
          k = run[i] - base[i];
          k = k + 0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
          if (k == RD || (k > RD && (k - RD) % RP == 0))
            e_press[i] = 1'b1;
`endif
        end
      end
      e_any = |e_press;
      m_p2 = m_p1;
      m_p1 = btn;
    end
  end

  always @(negedge clk) begin
    total++;
    if ({press, released, level, any_press}
        !== {e_press, e_rel, m_lvl, e_any}) begin
      bad++;
      $display("FAIL model t=%0t got p=%b r=%b l=%b a=%b want p=%b r=%b l=%b a=%b",
        $time, press, released, level, any_press,
        e_press, e_rel, m_lvl, e_any);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Counts negedges until the selected output is seen high; -1 on timeout.
  // sel: 0 press[ch], 1 released[ch], 2 any_press.
  task automatic first_pulse(input int ch, input int sel,
                             input int lim, output int k);
    bit hit;
    k = 0; hit = 0;
    while (!hit && k < lim) begin
      @(negedge clk);
      k++;
      unique case (sel)
        0: hit = press[ch];
        1: hit = released[ch];
        default: hit = any_press;
      endcase
    end
    if (!hit) k = -1;
  endtask

  initial begin
    int k, np, nr;
    int pos [$];
    int exp_pos [$];

    repeat (2) @(negedge clk);
    check("reset_outputs", int'({press, released, level, any_press}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press/release on ch0.
    btn[0] = 1'b0;
    first_pulse(0, 0, 40, k);
    check("clean_press_lat", k, 11);
    check("clean_level", int'(level), 1);
    repeat (19) @(negedge clk);
    btn[0] = 1'b1;
    first_pulse(0, 1, 40, k);
    check("clean_rel_lat", k, 11);
    check("clean_level_off", int'(level), 0);
    repeat (4) @(negedge clk);

    // Bounce on ch1.
    np = 0;
    for (int j = 0; j < 40; j++) begin
      if (j % 3 == 0) btn[1] = ~btn[1];
      @(negedge clk);
      if (press[1]) np++;
    end
    check("bounce_no_press", np, 0);
    btn[1] = 1'b0;
    first_pulse(1, 0, 40, k);
    check("bounce_press_lat", k, 11);
    btn[1] = 1'b1;
    first_pulse(1, 1, 40, k);
    check("bounce_rel_lat", k, 11);
    repeat (4) @(negedge clk);

    // Release glitch on ch2.
    btn[2] = 1'b0;
    first_pulse(2, 0, 40, k);
    check("glitch_press_lat", k, 11);
    repeat (3) @(negedge clk);
    btn[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn[2] = 1'b0;
    np = 0; nr = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (press[2]) np++;
      if (released[2]) nr++;
    end
    check("glitch_no_press", np, 0);
    check("glitch_no_release", nr, 0);
    check("glitch_level", int'(level[2]), 1);
    btn[2] = 1'b1;
    first_pulse(2, 1, 40, k);
    check("glitch_rel_lat", k, 11);
    repeat (4) @(negedge clk);

    // Simultaneous ch0 + ch3.
    btn[0] = 1'b0; btn[3] = 1'b0;
    first_pulse(0, 2, 40, k);
    check("simul_lat", k, 11);
    check("simul_press", int'(press), 9);
    check("simul_any", int'(any_press), 1);
    btn[0] = 1'b1;
    first_pulse(0, 1, 40, k);
    check("simul_rel0_lat", k, 11);
    repeat (4) @(negedge clk);

    // Reset while ch0 qualifies at count 5, ch3 still held.
    btn[0] = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          int'({press, released, level, any_press}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first_pulse(0, 0, 40, k);
    check("postreset_press_lat", k, 11);
    btn[0] = 1'b1; btn[3] = 1'b1;
    first_pulse(0, 1, 40, k);
    check("postreset_rel_lat", k, 11);
    repeat (4) @(negedge clk);

    // Long hold on ch0: repeat pulses when enabled.
    btn[0] = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (press[0]) pos.push_back(j);
    end
    exp_pos.push_back(11);
`ifdef BTN_DEBOUNCE_REPEAT_EN
    exp_pos.push_back(31); exp_pos.push_back(36);
    exp_pos.push_back(41); exp_pos.push_back(46);
    exp_pos.push_back(51); exp_pos.push_back(56);
`endif
    check("hold_press_count", pos.size(), exp_pos.size());
    for (int j = 0; j < exp_pos.size(); j++)
      check("hold_press_pos", (j < pos.size()) ? pos[j] : -1, exp_pos[j]);
    btn[0] = 1'b1;
    first_pulse(0, 1, 40, k);
    check("hold_rel_lat", k, 11);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
